// File: rtl/door_lock_ctrl.sv
// Per-stage keypad lock controller: collects four BCD digits, checks the stage passcode, drives
// the door sprite and reports stage_clear / stage_fail. Optional DOOR_AUTO_RELOCK_EN relock timer.
module door_lock_ctrl #(
  parameter logic [15:0] CODE1     = 16'h1234,
  parameter logic [15:0] CODE2     = 16'h2580,
  parameter logic [15:0] CODE3     = 16'h9731,
  parameter int unsigned MAX_TRIES = 3,
  parameter int unsigned FLASH_CYC = 25000000
`ifdef DOOR_AUTO_RELOCK_EN
  ,
  parameter int unsigned RELOCK_CYC = 500000000
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] state,
  input  logic       digit_valid,
  input  logic [3:0] digit,
  input  logic       clear,
  input  logic       player_at_door,
  output logic       isLocked,
  output logic [2:0] digit_cnt,
  output logic       err_flash,
  output logic       stage_clear,
  output logic       stage_fail
);

  localparam logic [3:0] Stage1 = 4'd2;
  localparam logic [3:0] Stage2 = 4'd4;
  localparam logic [3:0] Stage3 = 4'd6;
  localparam int unsigned TryW   = (MAX_TRIES > 1) ? $clog2(MAX_TRIES + 1) : 1;
  localparam int unsigned FlashW = (FLASH_CYC > 1) ? $clog2(FLASH_CYC + 1) : 1;
`ifdef DOOR_AUTO_RELOCK_EN
  localparam int unsigned RelockW = (RELOCK_CYC > 1) ? $clog2(RELOCK_CYC + 1) : 1;
`endif

  typedef enum logic [2:0] {
    StIdle,
    StEntry,
    StCheck,
    StError,
    StUnlocked,
    StDone
  } fsm_e;

  fsm_e              fsm_q;
  logic [3:0]        state_q;
  logic              pad_q;
  logic [15:0]       code_q;
  logic [15:0]       shift_q;
  logic [2:0]        cnt_q;
  logic [TryW-1:0]   tries_q;
  logic [FlashW-1:0] flash_q;
  logic              locked_q;
  logic              err_q;
  logic              sclr_q;
  logic              sfail_q;
`ifdef DOOR_AUTO_RELOCK_EN
  logic [RelockW-1:0] relock_q;
`endif

  logic        is_stage;
  logic [15:0] sel_code;

  always_comb begin
    is_stage = 1'b1;
    sel_code = CODE1;
    case (state)
      Stage1:  sel_code = CODE1;
      Stage2:  sel_code = CODE2;
      Stage3:  sel_code = CODE3;
      default: is_stage = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    // Input history tracks even through reset so no spurious change is seen afterwards.
    state_q <= state;
    pad_q   <= player_at_door;
    if (!rst_n || (state != state_q)) begin
      fsm_q    <= StIdle;
      code_q   <= '0;
      shift_q  <= '0;
      cnt_q    <= '0;
      tries_q  <= '0;
      flash_q  <= '0;
      locked_q <= 1'b1;
      err_q    <= 1'b0;
      sclr_q   <= 1'b0;
      sfail_q  <= 1'b0;
`ifdef DOOR_AUTO_RELOCK_EN
      relock_q <= '0;
`endif
    end else begin
      sclr_q  <= 1'b0;
      sfail_q <= 1'b0;
      case (fsm_q)
        StIdle: begin
          if (is_stage) begin
            fsm_q  <= StEntry;
            code_q <= sel_code;
          end
        end
        StEntry: begin
          if (clear) begin
            shift_q <= '0;
            cnt_q   <= '0;
          end else if (digit_valid && (digit <= 4'd9)) begin
            shift_q <= {shift_q[11:0], digit};
            cnt_q   <= cnt_q + 3'd1;
            if (cnt_q == 3'd3) fsm_q <= StCheck;
          end
        end
        StCheck: begin
          cnt_q   <= '0;
          shift_q <= '0;
          if (shift_q == code_q) begin
            fsm_q    <= StUnlocked;
            locked_q <= 1'b0;
            tries_q  <= '0;
`ifdef DOOR_AUTO_RELOCK_EN
            relock_q <= '0;
`endif
          end else if (tries_q == TryW'(MAX_TRIES - 1)) begin
            fsm_q   <= StDone;
            sfail_q <= 1'b1;
            tries_q <= tries_q + TryW'(1);
          end else begin
            fsm_q   <= StError;
            err_q   <= 1'b1;
            flash_q <= '0;
            tries_q <= tries_q + TryW'(1);
          end
        end
        StError: begin
          // err_flash rose on the CHECK edge, so it drops after FLASH_CYC cycles in total.
          if (flash_q == FlashW'(FLASH_CYC - 1)) begin
            err_q   <= 1'b0;
            flash_q <= '0;
            fsm_q   <= StEntry;
          end else begin
            flash_q <= flash_q + FlashW'(1);
          end
        end
        StUnlocked: begin
          if (player_at_door && !pad_q) begin
            fsm_q  <= StDone;
            sclr_q <= 1'b1;
          end
`ifdef DOOR_AUTO_RELOCK_EN
          else if (player_at_door) begin
            relock_q <= '0;
          end else if (relock_q == RelockW'(RELOCK_CYC - 1)) begin
            locked_q <= 1'b1;
            fsm_q    <= StEntry;
            cnt_q    <= '0;
            relock_q <= '0;
          end else begin
            relock_q <= relock_q + RelockW'(1);
          end
`endif
        end
        StDone:  ;
        default: fsm_q <= StIdle;
      endcase
    end
  end

  assign isLocked    = locked_q;
  assign digit_cnt   = cnt_q;
  assign err_flash   = err_q;
  assign stage_clear = sclr_q;
  assign stage_fail  = sfail_q;

endmodule

// File: tb/tb_door_lock_ctrl.sv
// Directed bench for door_lock_ctrl with a queue scoreboard; relock test runs only when
// DOOR_AUTO_RELOCK_EN is defined.
module tb_door_lock_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] state;
  logic       digit_valid;
  logic [3:0] digit;
  logic       clear;
  logic       player_at_door;
  logic       isLocked;
  logic [2:0] digit_cnt;
  logic       err_flash;
  logic       stage_clear;
  logic       stage_fail;

  int vectors = 0;
  int miscompares = 0;

  string       tag_q[$];
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  door_lock_ctrl #(
    .FLASH_CYC(4)
`ifdef DOOR_AUTO_RELOCK_EN
    ,
    .RELOCK_CYC(8)
`endif
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .state         (state),
    .digit_valid   (digit_valid),
    .digit         (digit),
    .clear         (clear),
    .player_at_door(player_at_door),
    .isLocked      (isLocked),
    .digit_cnt     (digit_cnt),
    .err_flash     (err_flash),
    .stage_clear   (stage_clear),
    .stage_fail    (stage_fail)
  );

  initial begin
    #100us;
    $display("FAIL watchdog: observed no finish, required finish before 100us");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input string t, input logic [31:0] v);
    tag_q.push_back(t);
    exp_q.push_back(v);
  endtask

  task automatic pop_cmp(input logic [31:0] obs);
    string       t;
    logic [31:0] e;
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $error("FAIL scoreboard_empty: observed %0h, no expected value queued", obs);
    end else begin
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      assert (obs === e) else begin
        miscompares++;
        $error("FAIL %s: observed %0h expected %0h", t, obs, e);
      end
    end
  endtask

  task automatic snap(input string t, input logic lk, input logic [2:0] c, input logic er,
                      input logic sc, input logic sf);
    push({t, ".isLocked"}, 32'(lk));
    push({t, ".digit_cnt"}, 32'(c));
    push({t, ".err_flash"}, 32'(er));
    push({t, ".stage_clear"}, 32'(sc));
    push({t, ".stage_fail"}, 32'(sf));
    pop_cmp(32'(isLocked));
    pop_cmp(32'(digit_cnt));
    pop_cmp(32'(err_flash));
    pop_cmp(32'(stage_clear));
    pop_cmp(32'(stage_fail));
  endtask

  task automatic press(input logic [3:0] d, input logic [2:0] exp_cnt);
    push("digit_cnt", 32'(exp_cnt));
    digit_valid = 1'b1;
    digit       = d;
    tick();
    digit_valid = 1'b0;
    digit       = 4'd0;
    pop_cmp(32'(digit_cnt));
  endtask

  task automatic enter_code(input logic [15:0] code);
    for (int i = 0; i < 4; i++) press(code[15-4*i -: 4], 3'(i + 1));
  endtask

  task automatic go_stage(input logic [3:0] s);
    state = 4'd0;
    tick();
    tick();
    state = s;
    tick();
    tick();
    tick();
  endtask

  // Counts remaining err_flash-high cycles; start is the count already observed high.
  task automatic flash_len(input string t, input int start);
    int n = start;
    int guard = 0;
    push(t, 32'd4);
    while (err_flash && guard < 20) begin
      tick();
      guard++;
      if (err_flash) n++;
    end
    pop_cmp(32'(n));
  endtask

  initial begin
    logic seen;
    rst_n = 1'b0;
    state = 4'd0;
    digit_valid = 1'b0;
    digit = 4'd0;
    clear = 1'b0;
    player_at_door = 1'b0;
    tick();
    tick();
    snap("reset", 1'b1, 3'd0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;

    // Stage 1: correct code, then walk through the door.
    go_stage(4'd2);
    enter_code(16'h1234);
    snap("s1_n1", 1'b1, 3'd4, 1'b0, 1'b0, 1'b0);
    tick();
    snap("s1_unlock", 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    player_at_door = 1'b1;
    tick();
    snap("s1_clear", 1'b0, 3'd0, 1'b0, 1'b1, 1'b0);
    tick();
    snap("s1_clear_once", 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    player_at_door = 1'b0;
    tick();
    player_at_door = 1'b1;
    tick();
    snap("s1_done_hold", 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    player_at_door = 1'b0;

    // Stage 2: three wrong attempts.
    go_stage(4'd4);
    enter_code(16'h1111);
    tick();
    snap("s2_err1", 1'b1, 3'd0, 1'b1, 1'b0, 1'b0);
    flash_len("s2_flash1_len", 1);
    snap("s2_err1_end", 1'b1, 3'd0, 1'b0, 1'b0, 1'b0);
    enter_code(16'h1111);
    tick();
    snap("s2_err2", 1'b1, 3'd0, 1'b1, 1'b0, 1'b0);
    press(4'd5, 3'd0);
    flash_len("s2_flash2_len", 2);
    enter_code(16'h1111);
    tick();
    snap("s2_fail", 1'b1, 3'd0, 1'b0, 1'b0, 1'b1);
    tick();
    snap("s2_fail_once", 1'b1, 3'd0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    snap("s2_done_hold", 1'b1, 3'd0, 1'b0, 1'b0, 1'b0);

    // Stage 2 again: partial entry, clear, then correct code with player already at door.
    go_stage(4'd4);
    press(4'd2, 3'd1);
    press(4'd5, 3'd2);
    push("s3_clear_cnt", 32'd0);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    pop_cmp(32'(digit_cnt));
    player_at_door = 1'b1;
    enter_code(16'h2580);
    tick();
    snap("s3_unlock", 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      seen = seen | stage_clear;
    end
    push("s3_no_pulse_when_held", 32'd0);
    pop_cmp(32'(seen));
    player_at_door = 1'b0;
    tick();
    player_at_door = 1'b1;
    tick();
    snap("s3_clear", 1'b0, 3'd0, 1'b0, 1'b1, 1'b0);
    player_at_door = 1'b0;

    // Invalid digit and clear+digit collision.
    go_stage(4'd2);
    press(4'hB, 3'd0);
    press(4'd1, 3'd1);
    press(4'd2, 3'd2);
    push("s4_clear_wins", 32'd0);
    clear = 1'b1;
    digit_valid = 1'b1;
    digit = 4'd7;
    tick();
    clear = 1'b0;
    digit_valid = 1'b0;
    pop_cmp(32'(digit_cnt));
    press(4'd1, 3'd1);
    press(4'd2, 3'd2);
    press(4'hB, 3'd2);
    press(4'd3, 3'd3);
    press(4'd4, 3'd4);
    tick();
    snap("s4_unlock", 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);

    // Stage 3 unlock, leave stage; state change overrides a pending CHECK; reset mid-ERROR.
    go_stage(4'd6);
    enter_code(16'h9731);
    tick();
    snap("s5_unlock", 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    state = 4'd8;
    tick();
    snap("s5_leave", 1'b1, 3'd0, 1'b0, 1'b0, 1'b0);
    go_stage(4'd6);
    enter_code(16'h9731);
    state = 4'd2;
    tick();
    snap("s5_check_abort", 1'b1, 3'd0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    enter_code(16'h1234);
    tick();
    snap("s5_relatch_code", 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    go_stage(4'd6);
    enter_code(16'h0000);
    tick();
    snap("s5_err", 1'b1, 3'd0, 1'b1, 1'b0, 1'b0);
    tick();
    rst_n = 1'b0;
    tick();
    snap("s5_reset", 1'b1, 3'd0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    tick();
    tick();
    enter_code(16'h9731);
    tick();
    snap("s5_after_reset", 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);

`ifdef DOOR_AUTO_RELOCK_EN
    go_stage(4'd2);
    enter_code(16'h1234);
    tick();
    snap("s6_unlock", 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    repeat (7) tick();
    snap("s6_pre_relock", 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    tick();
    snap("s6_relock", 1'b1, 3'd0, 1'b0, 1'b0, 1'b0);
    enter_code(16'h1234);
    tick();
    snap("s6_reunlock", 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
